mem_wb_stage: RTL and testbench

- MEM→WB pipeline boundary of the ARC MIPS core.
- Registers MEM-stage results and control, and extracts and extends load data by byte lane.
- Stalls the pipe while data memory has not returned a load word.
- Its outputs drive the writeback result mux directly (ALU result, aligned read data, memtoreg select) and the register-file write port.

---
 rtl/mem_wb_stage_if.sv | 42 ++++
 rtl/mem_wb_stage.sv | 125 ++++++++++++
 tb/tb_mem_wb_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM->WB boundary bundle: MEM-stage results and control in, registered WB fields out.
// The stage binds to the slave modport and the producer/consumer side binds to master.
interface mem_wb_stage_if #(
   parameter int DW = 32,
   parameter int RW = 5
);
   logic [DW-1:0] i_data_aluresM;
   logic [DW-1:0] i_data_readM;
   logic          i_mem_rvalid;
   logic [RW-1:0] i_addr_writeregM;
   logic          i_con_regwriteM;
   logic          i_con_memtoregM;
   logic [2:0]    i_con_loadtypeM;
   logic          i_con_validM;
   logic          i_con_stallW;
   logic          i_con_flushW;

   logic [DW-1:0] o_data_aluresW;
   logic [DW-1:0] o_data_readW;
   logic          o_con_memtoregW;
   logic          o_con_regwriteW;
   logic [RW-1:0] o_addr_writeregW;
   logic          o_con_validW;
   logic          o_con_memwait;
   logic          o_con_misalign;

   modport slave (
      input  i_data_aluresM, i_data_readM, i_mem_rvalid, i_addr_writeregM,
             i_con_regwriteM, i_con_memtoregM, i_con_loadtypeM, i_con_validM,
             i_con_stallW, i_con_flushW,
      output o_data_aluresW, o_data_readW, o_con_memtoregW, o_con_regwriteW,
             o_addr_writeregW, o_con_validW, o_con_memwait, o_con_misalign
   );

   modport master (
      output i_data_aluresM, i_data_readM, i_mem_rvalid, i_addr_writeregM,
             i_con_regwriteM, i_con_memtoregM, i_con_loadtypeM, i_con_validM,
             i_con_stallW, i_con_flushW,
      input  o_data_aluresW, o_data_readW, o_con_memtoregW, o_con_regwriteW,
             o_addr_writeregW, o_con_validW, o_con_memwait, o_con_misalign
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: byte-lane load alignment/extension, misalign drop,
// and a load-wait FSM that bubbles WB and stalls upstream until the read word returns.
//
//   state   | meaning
//   IDLE    | no load outstanding
//   WAIT    | aligned load presented, data memory has not returned the word yet
module mem_wb_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input logic           i_clk,
   input logic           i_rst,
   mem_wb_stage_if.slave bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam logic [2:0] LT_LH  = 3'b001;
   localparam logic [2:0] LT_LHU = 3'b010;
   localparam logic [2:0] LT_LB  = 3'b011;
   localparam logic [2:0] LT_LBU = 3'b100;

   logic [0:0]    state, state_nxt;
   logic          load, misalign, mem_wait;
   logic [1:0]    lane;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [DW-1:0] load_data;

   logic [DW-1:0] alures_q, read_q;
   logic [RW-1:0] writereg_q;
   logic          memtoreg_q, regwrite_q, valid_q, misalign_q;

   always_comb begin
      lane     = bus.i_data_aluresM[1:0];
      load     = bus.i_con_validM & bus.i_con_memtoregM;
      misalign = 1'b0;
      case (bus.i_con_loadtypeM)
         LT_LH, LT_LHU: misalign = load & lane[0];
         LT_LB, LT_LBU: misalign = 1'b0;
         default:       misalign = load & (lane != 2'b00);
      endcase
      // Misaligned loads are dropped, so they never hold the pipe for memory.
      mem_wait = ~i_rst & load & ~misalign & ~bus.i_mem_rvalid & ~bus.i_con_flushW;
   end

   always_comb begin
      byte_sel = 8'h00;
      case (lane)
         2'd0:    byte_sel = bus.i_data_readM[7:0];
         2'd1:    byte_sel = bus.i_data_readM[15:8];
         2'd2:    byte_sel = bus.i_data_readM[23:16];
         default: byte_sel = bus.i_data_readM[31:24];
      endcase
      half_sel = lane[1] ? bus.i_data_readM[31:16] : bus.i_data_readM[15:0];
      case (bus.i_con_loadtypeM)
         LT_LB:   load_data = {{(DW-8){byte_sel[7]}}, byte_sel};
         LT_LBU:  load_data = {{(DW-8){1'b0}}, byte_sel};
         LT_LH:   load_data = {{(DW-16){half_sel[15]}}, half_sel};
         LT_LHU:  load_data = {{(DW-16){1'b0}}, half_sel};
         default: load_data = bus.i_data_readM;
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (bus.i_con_flushW) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (mem_wait) state_nxt = ST_WAIT;
            ST_WAIT: if (bus.i_mem_rvalid) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         alures_q   <= '0;
         read_q     <= '0;
         writereg_q <= '0;
         memtoreg_q <= 1'b0;
         regwrite_q <= 1'b0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else if (bus.i_con_flushW) begin
         state      <= ST_IDLE;
         memtoreg_q <= 1'b0;
         regwrite_q <= 1'b0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else if (bus.i_con_stallW) begin
         misalign_q <= 1'b0;
      end else if (mem_wait) begin
         // Bubble while the load word is outstanding; data fields keep their last value.
         state      <= state_nxt;
         memtoreg_q <= 1'b0;
         regwrite_q <= 1'b0;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         alures_q   <= bus.i_data_aluresM;
         read_q     <= load ? load_data : '0;
         writereg_q <= bus.i_addr_writeregM;
         memtoreg_q <= bus.i_con_memtoregM;
         regwrite_q <= bus.i_con_regwriteM & bus.i_con_validM & ~misalign;
         valid_q    <= bus.i_con_validM;
         misalign_q <= misalign;
      end
   end

   assign bus.o_data_aluresW   = alures_q;
   assign bus.o_data_readW     = read_q;
   assign bus.o_addr_writeregW = writereg_q;
   assign bus.o_con_memtoregW  = memtoreg_q;
   assign bus.o_con_regwriteW  = regwrite_q;
   assign bus.o_con_validW     = valid_q;
   assign bus.o_con_misalign   = misalign_q;
   assign bus.o_con_memwait    = mem_wait;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a randomized run
// scored against a rule-level model of the WB register contents.
module tb_mem_wb_stage;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   mem_wb_stage_if #(.DW(32), .RW(5)) bus ();

   mem_wb_stage #(.DW(32), .RW(5)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state: what WB should hold after the last edge
   logic [31:0] e_alu, e_read;
   logic [4:0]  e_addr;
   logic        e_mtr, e_rw, e_valid, e_mis;

   task automatic drive(input logic [31:0] alu, input logic [31:0] rdata, input logic rv,
                        input logic [4:0] rd, input logic rw, input logic mtr,
                        input logic [2:0] lt, input logic v);
      bus.i_data_aluresM   = alu;
      bus.i_data_readM     = rdata;
      bus.i_mem_rvalid     = rv;
      bus.i_addr_writeregM = rd;
      bus.i_con_regwriteM  = rw;
      bus.i_con_memtoregM  = mtr;
      bus.i_con_loadtypeM  = lt;
      bus.i_con_validM     = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_extract(input logic [31:0] rdata, input logic [31:0] alu,
                                                 input logic [2:0] lt);
      logic [31:0] b, h;
      int sh;
      sh = int'(alu % 4);
      b  = (rdata >> (8 * sh)) % 256;
      h  = (rdata >> (16 * (sh / 2))) % 65536;
      case (lt)
         3'd3:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd2:    return h;
         default: return rdata;
      endcase
   endfunction

   function automatic logic model_misalign(input logic [31:0] alu, input logic [2:0] lt);
      int off;
      off = int'(alu % 4);
      if (lt == 3'd3 || lt == 3'd4) return 1'b0;
      if (lt == 3'd1 || lt == 3'd2) return (off % 2) != 0;
      return off != 0;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive($urandom, $urandom, 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
               3'($urandom), 1'($urandom));
         bus.i_con_stallW = 1'($urandom);
         bus.i_con_flushW = 1'($urandom);
         #1;
         checks++;
         if (bus.o_con_memwait !== 1'b0) begin
            failures++;
            $display("FAIL reset_memwait cycle=%0d got=%b want=0", i, bus.o_con_memwait);
         end
         step();
         checks++;
         if ({bus.o_data_aluresW, bus.o_data_readW, bus.o_addr_writeregW, bus.o_con_memtoregW,
              bus.o_con_regwriteW, bus.o_con_validW, bus.o_con_misalign} !== 73'd0) begin
            failures++;
            $display("FAIL reset_outputs cycle=%0d alu=%h read=%h addr=%0d mtr=%b rw=%b v=%b mis=%b want all 0",
                     i, bus.o_data_aluresW, bus.o_data_readW, bus.o_addr_writeregW,
                     bus.o_con_memtoregW, bus.o_con_regwriteW, bus.o_con_validW, bus.o_con_misalign);
         end
      end
      rst = 1'b0;
      bus.i_con_stallW = 1'b0;
      bus.i_con_flushW = 1'b0;
      drive(32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 5'd5, 1'b1, 1'b0, 3'd0, 1'b1);
      #1;
      checks++;
      if (bus.o_con_memwait !== 1'b0) begin
         failures++;
         $display("FAIL add_memwait got=%b want=0", bus.o_con_memwait);
      end
      step();
      checks++;
      if ({bus.o_con_validW, bus.o_con_regwriteW, bus.o_addr_writeregW, bus.o_data_aluresW,
           bus.o_data_readW, bus.o_con_memtoregW, bus.o_con_misalign} !==
          {1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL add_capture v=%b rw=%b addr=%0d alu=%h read=%h mtr=%b mis=%b want 1 1 5 00001234 0 0 0",
                  bus.o_con_validW, bus.o_con_regwriteW, bus.o_addr_writeregW, bus.o_data_aluresW,
                  bus.o_data_readW, bus.o_con_memtoregW, bus.o_con_misalign);
      end
   endtask

   task automatic test_byte_ext();
      logic [2:0]  lts  [3] = '{3'd3, 3'd4, 3'd3};
      logic [31:0] addrs[3] = '{32'h0000_4001, 32'h0000_4001, 32'h0000_4002};
      logic [31:0] exps [3] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_FF80};
      for (int i = 0; i < 3; i++) begin
         drive(addrs[i], 32'h1280_FF34, 1'b1, 5'd7, 1'b1, 1'b1, lts[i], 1'b1);
         step();
         checks++;
         if ({bus.o_data_readW, bus.o_con_validW, bus.o_con_regwriteW, bus.o_con_memtoregW} !==
             {exps[i], 1'b1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL byte_ext case=%0d read=%h v=%b rw=%b mtr=%b want read=%h v=1 rw=1 mtr=1",
                     i, bus.o_data_readW, bus.o_con_validW, bus.o_con_regwriteW,
                     bus.o_con_memtoregW, exps[i]);
         end
      end
   endtask

   task automatic test_half_word();
      logic [2:0]  lts  [3] = '{3'd1, 3'd2, 3'd0};
      logic [31:0] addrs[3] = '{32'h0000_8002, 32'h0000_8002, 32'h0000_8000};
      logic [31:0] exps [3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_7FFF};
      for (int i = 0; i < 3; i++) begin
         drive(addrs[i], 32'h8001_7FFF, 1'b1, 5'd9, 1'b1, 1'b1, lts[i], 1'b1);
         step();
         checks++;
         if ({bus.o_data_readW, bus.o_con_validW, bus.o_con_regwriteW, bus.o_con_misalign} !==
             {exps[i], 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL half_word case=%0d read=%h v=%b rw=%b mis=%b want read=%h v=1 rw=1 mis=0",
                     i, bus.o_data_readW, bus.o_con_validW, bus.o_con_regwriteW,
                     bus.o_con_misalign, exps[i]);
         end
      end
   endtask

   task automatic test_mem_wait();
      drive(32'h0000_0100, 32'h0, 1'b0, 5'd12, 1'b1, 1'b1, 3'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.o_con_memwait !== 1'b1) begin
            failures++;
            $display("FAIL wait_memwait cycle=%0d got=%b want=1", i, bus.o_con_memwait);
         end
         step();
         checks++;
         if ({bus.o_con_validW, bus.o_con_regwriteW} !== 2'b00) begin
            failures++;
            $display("FAIL wait_bubble cycle=%0d v=%b rw=%b want 0 0", i, bus.o_con_validW,
                     bus.o_con_regwriteW);
         end
      end
      drive(32'h0000_0100, 32'hCAFE_BABE, 1'b1, 5'd12, 1'b1, 1'b1, 3'd0, 1'b1);
      #1;
      checks++;
      if (bus.o_con_memwait !== 1'b0) begin
         failures++;
         $display("FAIL wait_release got=%b want=0", bus.o_con_memwait);
      end
      step();
      checks++;
      if ({bus.o_con_validW, bus.o_con_regwriteW, bus.o_con_memtoregW, bus.o_addr_writeregW,
           bus.o_data_readW} !== {1'b1, 1'b1, 1'b1, 5'd12, 32'hCAFE_BABE}) begin
         failures++;
         $display("FAIL wait_load v=%b rw=%b mtr=%b addr=%0d read=%h want 1 1 1 12 cafebabe",
                  bus.o_con_validW, bus.o_con_regwriteW, bus.o_con_memtoregW,
                  bus.o_addr_writeregW, bus.o_data_readW);
      end
   endtask

   task automatic test_flush_wait();
      drive(32'h0000_0200, 32'h0, 1'b0, 5'd3, 1'b1, 1'b1, 3'd0, 1'b1);
      #1;
      checks++;
      if (bus.o_con_memwait !== 1'b1) begin
         failures++;
         $display("FAIL flush_wait_enter got=%b want=1", bus.o_con_memwait);
      end
      step();
      bus.i_con_flushW = 1'b1;
      #1;
      checks++;
      if (bus.o_con_memwait !== 1'b0) begin
         failures++;
         $display("FAIL flush_memwait got=%b want=0", bus.o_con_memwait);
      end
      step();
      checks++;
      if ({bus.o_con_validW, bus.o_con_regwriteW, bus.o_con_misalign} !== 3'b000) begin
         failures++;
         $display("FAIL flush_bubble v=%b rw=%b mis=%b want 0 0 0", bus.o_con_validW,
                  bus.o_con_regwriteW, bus.o_con_misalign);
      end
      bus.i_con_flushW = 1'b0;
      drive(32'h0000_0040, 32'h55AA_1234, 1'b1, 5'd4, 1'b1, 1'b0, 3'd0, 1'b1);
      #1;
      checks++;
      if (bus.o_con_memwait !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_memwait got=%b want=0", bus.o_con_memwait);
      end
      step();
      checks++;
      if ({bus.o_con_validW, bus.o_con_regwriteW, bus.o_data_aluresW} !== {1'b1, 1'b1, 32'h40}) begin
         failures++;
         $display("FAIL flush_resume v=%b rw=%b alu=%h want 1 1 00000040", bus.o_con_validW,
                  bus.o_con_regwriteW, bus.o_data_aluresW);
      end
   endtask

   task automatic test_misalign_stall();
      drive(32'h0000_0302, 32'h1111_2222, 1'b0, 5'd21, 1'b1, 1'b1, 3'd0, 1'b1);
      #1;
      checks++;
      if (bus.o_con_memwait !== 1'b0) begin
         failures++;
         $display("FAIL misalign_nowait got=%b want=0", bus.o_con_memwait);
      end
      step();
      checks++;
      if ({bus.o_con_validW, bus.o_con_regwriteW, bus.o_con_misalign, bus.o_addr_writeregW} !==
          {1'b1, 1'b0, 1'b1, 5'd21}) begin
         failures++;
         $display("FAIL misalign_capture v=%b rw=%b mis=%b addr=%0d want 1 0 1 21", bus.o_con_validW,
                  bus.o_con_regwriteW, bus.o_con_misalign, bus.o_addr_writeregW);
      end
      bus.i_con_stallW = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(32'h0000_0500 + i, 32'h0, 1'b1, 5'd30 - 5'(i), 1'b1, 1'b0, 3'd0, 1'b1);
         step();
         checks++;
         if ({bus.o_con_validW, bus.o_con_regwriteW, bus.o_con_misalign, bus.o_addr_writeregW,
              bus.o_data_aluresW} !== {1'b1, 1'b0, 1'b0, 5'd21, 32'h0000_0302}) begin
            failures++;
            $display("FAIL stall_hold cycle=%0d v=%b rw=%b mis=%b addr=%0d alu=%h want 1 0 0 21 00000302",
                     i, bus.o_con_validW, bus.o_con_regwriteW, bus.o_con_misalign,
                     bus.o_addr_writeregW, bus.o_data_aluresW);
         end
      end
      bus.i_con_flushW = 1'b1;
      step();
      checks++;
      if ({bus.o_con_validW, bus.o_con_regwriteW, bus.o_con_misalign} !== 3'b000) begin
         failures++;
         $display("FAIL flush_stall v=%b rw=%b mis=%b want 0 0 0", bus.o_con_validW,
                  bus.o_con_regwriteW, bus.o_con_misalign);
      end
      bus.i_con_flushW = 1'b0;
      bus.i_con_stallW = 1'b0;
   endtask

   task automatic test_random();
      logic        exp_wait, mis, ld;
      logic [31:0] alu, rdata;
      logic [2:0]  lt;
      logic [4:0]  rd;
      logic        rv, rw, mtr, v;
      for (int n = 0; n < 400; n++) begin
         alu   = $urandom;
         rdata = $urandom;
         lt    = 3'($urandom);
         rd    = 5'($urandom);
         rv    = ($urandom % 3) != 0;
         rw    = 1'($urandom);
         mtr   = ($urandom % 2) == 0;
         v     = ($urandom % 4) != 0;
         drive(alu, rdata, rv, rd, rw, mtr, lt, v);
         rst              = (n == 0) || ($urandom % 25 == 0);
         bus.i_con_flushW = ($urandom % 10 == 0);
         bus.i_con_stallW = ($urandom % 8 == 0);
         ld  = v && mtr;
         mis = ld && model_misalign(alu, lt);
         exp_wait = !rst && ld && !mis && !rv && !bus.i_con_flushW;
         #1;
         checks++;
         if (bus.o_con_memwait !== exp_wait) begin
            failures++;
            $display("FAIL rand_memwait n=%0d got=%b want=%b", n, bus.o_con_memwait, exp_wait);
         end
         if (rst) begin
            {e_alu, e_read, e_addr, e_mtr, e_rw, e_valid, e_mis} = '0;
         end else if (bus.i_con_flushW) begin
            {e_mtr, e_rw, e_valid, e_mis} = '0;
         end else if (bus.i_con_stallW) begin
            e_mis = 1'b0;
         end else if (exp_wait) begin
            {e_mtr, e_rw, e_valid, e_mis} = '0;
         end else begin
            e_alu   = alu;
            e_addr  = rd;
            e_mtr   = mtr;
            e_valid = v;
            e_mis   = mis;
            e_rw    = rw && v && !mis;
            e_read  = ld ? model_extract(rdata, alu, lt) : 32'h0;
         end
         step();
         checks++;
         if ({bus.o_con_validW, bus.o_con_regwriteW, bus.o_con_misalign} !== {e_valid, e_rw, e_mis} ||
             (e_valid && {bus.o_data_aluresW, bus.o_addr_writeregW, bus.o_con_memtoregW} !==
                         {e_alu, e_addr, e_mtr}) ||
             (e_valid && !e_mis && bus.o_data_readW !== e_read)) begin
            failures++;
            $display("FAIL rand_wb n=%0d got v=%b rw=%b mis=%b alu=%h addr=%0d mtr=%b read=%h want v=%b rw=%b mis=%b alu=%h addr=%0d mtr=%b read=%h",
                     n, bus.o_con_validW, bus.o_con_regwriteW, bus.o_con_misalign,
                     bus.o_data_aluresW, bus.o_addr_writeregW, bus.o_con_memtoregW, bus.o_data_readW,
                     e_valid, e_rw, e_mis, e_alu, e_addr, e_mtr, e_read);
         end
      end
      rst              = 1'b0;
      bus.i_con_flushW = 1'b0;
      bus.i_con_stallW = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.i_con_stallW = 1'b0;
      bus.i_con_flushW = 1'b0;
      drive(32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
      step();
      test_reset();
      test_byte_ext();
      test_half_word();
      test_mem_wait();
      test_flush_wait();
      test_misalign_stall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
